unary_to_binary_decoder: RTL and testbench
==========================================

Name: unary_to_binary_decoder

Overview:
- Downstream stage of the unary multiply-by-two unit. Consumes its serial bitstream (y/valid) and counts ones over fixed frames of FRAME_LEN accepted bits.
- Emits each frame's ones-count as a binary value through a valid/ready output handshake.
- The accumulator and the output register are separate, so the next frame accumulates while the previous result waits to be consumed.
- Input backpressure (in_ready) is asserted only when both the accumulator and the output register hold completed frames.

Parameters:
- FRAME_LEN, 32, number of accepted bits per frame; must be >= 2.
- COUNT_WIDTH, $clog2(FRAME_LEN+1), width of all counters and out_value.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_bit  input  1  unary stream bit, driven from the upstream y.
- in_valid  input  1  in_bit is meaningful this cycle, driven from the upstream valid.
- in_ready  output  1  decoder accepts a bit this cycle; combinational from state.
- out_value  output  COUNT_WIDTH  ones-count of the completed frame, range 0..FRAME_LEN.
- out_valid  output  1  out_value holds an unconsumed result.
- out_ready  input  1  downstream consumes out_value when out_valid && out_ready.

Behaviour:
- Reset values (async, immediate): state=ACCUM, bit_cnt=0, ones_cnt=0, out_value=0, out_valid=0. in_ready=1 as soon as reset deasserts.
- Accept condition: in_valid && in_ready. On accept, bit_cnt+=1 and ones_cnt+=in_bit. No change on cycles without an accept.
- States: ACCUM and STALL.
  - in_ready=1 in ACCUM.
  - in_ready=0 in STALL.
- Frame completion: an accept in ACCUM with bit_cnt==FRAME_LEN-1.
  - Slot free (out_valid==0, or out_valid && out_ready this cycle):
    - next edge: out_value<=ones_cnt+in_bit, out_valid<=1, bit_cnt<=0, ones_cnt<=0.
    - state stays ACCUM.
    - Latency: the result is visible the cycle after the final bit is accepted.
  - Slot busy:
    - ones_cnt<=ones_cnt+in_bit, bit_cnt<=FRAME_LEN, state<=STALL.
- Output consume (out_valid && out_ready) with no new frame completing: out_valid<=0 and out_value holds its last value. Consume plus frame completion on the same edge: the new frame loads and out_valid stays 1.
- STALL:
  - in_ready=0 and no bits are accepted; in_valid pulses in STALL are ignored.
  - The upstream must treat in_ready as its ready/enable, so it holds its stream.
  - On out_ready (out_valid is necessarily 1): out_value<=ones_cnt, out_valid stays 1, both counters <=0, state<=ACCUM.
- Arithmetic:
  - All counts are unsigned COUNT_WIDTH.
  - ones_cnt <= bit_cnt <= FRAME_LEN by construction, so no wrap is possible.
  - All-ones frame gives out_value=FRAME_LEN; all-zeros frame gives out_value=0.
- out_value is stable while out_valid=1 and out_ready=0.
- Reset mid-frame or mid-STALL: partial counts and any pending result are discarded, and the block returns to the reset state.

Optional Feature:
- Macro: UNARY_DEC_FLUSH_EN.
- Enabled:
  - adds input flush (1 bit) and output out_partial (1 bit, reset 0).
  - flush=1 in ACCUM with bit_cnt>0 (including any bit accepted that cycle) ends the frame early, using the same slot-free/STALL rules.
  - out_partial=1 accompanies that result.
  - out_partial is 0 for full frames.
  - flush with bit_cnt==0 and no accept: no effect.
  - flush in STALL: ignored.
- Disabled: neither port exists and frames end only at FRAME_LEN bits.

Test Plan:
- FRAME_LEN=8, out_ready=1, stream 1,1,0,1,0,0,1,1 with in_valid=1 continuously -> out_valid=1 for one cycle, the cycle after the 8th accept, with out_value=5; in_ready stays 1 throughout.
- in_valid toggling 1,0,1,0 over an all-ones frame -> only valid cycles counted; out_value=8 after 8 accepts (16 cycles).
- out_ready=0, two consecutive all-zeros frames -> first frame gives out_value=0, out_valid=1; after the 16th accept, in_ready=0 (STALL). Raising out_ready for 1 cycle -> out_value=0 still valid (second frame) and in_ready=1 the next cycle.
- In STALL, drive in_valid=1, in_bit=1 for 5 cycles -> bit_cnt unchanged, and the pending result equals the pre-stall count on release.
- Assert reset mid-frame after 3 ones -> out_valid=0 and out_value=0 immediately; the next full frame of 8 ones gives out_value=8, not 11.
- With UNARY_DEC_FLUSH_EN: 3 bits 1,0,1 then flush=1 -> out_value=2, out_partial=1; the following full frame gives out_partial=0.

Source files
------------

// File: rtl/unary_to_binary_decoder.sv
// rtl/unary_to_binary_decoder.sv - counts ones over FRAME_LEN-bit frames of a unary stream, emits binary counts
// Optional early-frame flush enabled by defining UNARY_DEC_FLUSH_EN.
module unary_to_binary_decoder #(
  parameter int FRAME_LEN   = 32,
  parameter int COUNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_bit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [COUNT_WIDTH-1:0] out_value,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef UNARY_DEC_FLUSH_EN
  ,
  input  logic                   flush,
  output logic                   out_partial
`endif
);

  typedef enum logic {ACCUM, STALL} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(FRAME_LEN - 1);

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] bit_cnt;
  logic [COUNT_WIDTH-1:0] ones_cnt;
  logic [COUNT_WIDTH-1:0] bit_sum;
  logic [COUNT_WIDTH-1:0] ones_sum;
  logic                   accept;
  logic                   full_done;
  logic                   end_frame;
  logic                   slot_free;

  assign in_ready = (state == ACCUM);

  always_comb begin
    accept     = in_valid && (state == ACCUM);
    bit_sum    = bit_cnt + COUNT_WIDTH'(accept);
    ones_sum   = ones_cnt + COUNT_WIDTH'(accept && in_bit);
    full_done  = accept && (bit_cnt == LAST_IDX);
    end_frame  = full_done;
`ifdef UNARY_DEC_FLUSH_EN
    // A flush only ends a frame that has at least one bit, counting this cycle's accept.
    end_frame  = full_done || (flush && (state == ACCUM) && (bit_sum != '0));
`endif
    slot_free  = !out_valid || out_ready;
    state_next = state;
    case (state)
      ACCUM: if (end_frame && !slot_free) state_next = STALL;
      STALL: if (out_ready)               state_next = ACCUM;
      default:                            state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (end_frame && slot_free) begin
            out_value <= ones_sum;
            out_valid <= 1'b1;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
          end else if (end_frame) begin
            // Output slot still occupied: park the finished frame in the accumulator.
            bit_cnt  <= bit_sum;
            ones_cnt <= ones_sum;
          end else begin
            bit_cnt  <= bit_sum;
            ones_cnt <= ones_sum;
            if (out_valid && out_ready) out_valid <= 1'b0;
          end
        end
        STALL: begin
          if (out_ready) begin
            out_value <= ones_cnt;
            out_valid <= 1'b1;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UNARY_DEC_FLUSH_EN
  logic pend_partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_partial  <= 1'b0;
      pend_partial <= 1'b0;
    end else if ((state == ACCUM) && end_frame) begin
      if (slot_free) out_partial  <= !full_done;
      else           pend_partial <= !full_done;
    end else if ((state == STALL) && out_ready) begin
      out_partial <= pend_partial;
    end
  end
`endif

endmodule

// File: tb/tb_unary_to_binary_decoder.sv
// tb/tb_unary_to_binary_decoder.sv - directed self-checking bench for unary_to_binary_decoder
// Define UNARY_DEC_FLUSH_EN to also exercise the flush port.
module tb_unary_to_binary_decoder;

  localparam int FL = 8;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_bit;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] out_value;
  logic          out_valid;
  logic          out_ready;
`ifdef UNARY_DEC_FLUSH_EN
  logic          flush;
  logic          out_partial;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  unary_to_binary_decoder #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef UNARY_DEC_FLUSH_EN
    ,
    .flush     (flush),
    .out_partial (out_partial)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FL-1:0] bits);
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      cycle();
    end
    in_valid = 1'b0;
  endtask

  logic [FL-1:0] pat;

  initial begin
    reset     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef UNARY_DEC_FLUSH_EN
    flush     = 1'b0;
`endif
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_value", out_value, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Frame 1,1,0,1,0,0,1,1 with out_ready high
    pat = 8'b1100_1011;
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[i];
      check("t1_in_ready", in_ready, 1);
      if (i == FL - 1) check("t1_no_early_valid", out_valid, 0);
      cycle();
    end
    in_valid = 1'b0;
    check("t1_out_valid", out_valid, 1);
    check("t1_out_value", out_value, 5);
    cycle();
    check("t1_consumed", out_valid, 0);
    check("t1_value_hold", out_value, 5);

    // in_valid toggling over an all-ones frame
    for (int c = 0; c < 16; c++) begin
      in_valid = (c % 2 == 0);
      in_bit   = 1'b1;
      cycle();
      if (c == 13) check("t2_not_yet", out_valid, 0);
      if (c == 14) begin
        check("t2_out_valid", out_valid, 1);
        check("t2_out_value", out_value, 8);
      end
    end
    in_valid = 1'b0;
    check("t2_consumed", out_valid, 0);

    // Two all-zeros frames with out_ready low -> STALL
    out_ready = 1'b0;
    send_frame('0);
    check("t3_f1_valid", out_valid, 1);
    check("t3_f1_value", out_value, 0);
    check("t3_f1_in_ready", in_ready, 1);
    send_frame('0);
    check("t3_stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    check("t3_rel_valid", out_valid, 1);
    check("t3_rel_value", out_value, 0);
    check("t3_rel_in_ready", in_ready, 1);
    cycle();
    check("t3_drain", out_valid, 0);

    // STALL ignores in_valid pulses
    out_ready = 1'b0;
    send_frame('1);
    check("t4_a_value", out_value, 8);
    send_frame(8'b1000_0101);
    check("t4_stall", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("t4_still_stall", in_ready, 0);
    check("t4_value_stable", out_value, 8);
    out_ready = 1'b1;
    cycle();
    check("t4_rel_value", out_value, 3);
    check("t4_rel_valid", out_valid, 1);
    check("t4_rel_in_ready", in_ready, 1);

    // Consume and completion on the same edge
    out_ready = 1'b0;
    pat = 8'b0000_0011;
    for (int i = 0; i < FL; i++) begin
      in_valid  = 1'b1;
      in_bit    = pat[i];
      out_ready = (i == FL - 1);
      cycle();
    end
    in_valid = 1'b0;
    check("t5_valid", out_valid, 1);
    check("t5_value", out_value, 2);
    check("t5_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    check("t5_drain", out_valid, 0);

    // Reset mid-frame discards partial and pending results
    out_ready = 1'b0;
    send_frame('1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("t6_pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_value", out_value, 0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      cycle();
      if (i == 4) check("t6_no_leftover", out_valid, 0);
    end
    in_valid = 1'b0;
    check("t6_value", out_value, 8);
    check("t6_valid", out_valid, 1);
    cycle();

`ifdef UNARY_DEC_FLUSH_EN
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("f_empty_flush", out_valid, 0);
    pat = 8'b0000_0101;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[i];
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    cycle();
    flush = 1'b0;
    check("f_valid", out_valid, 1);
    check("f_value", out_value, 2);
    check("f_partial", out_partial, 1);
    send_frame('1);
    check("f_full_value", out_value, 8);
    check("f_full_partial", out_partial, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
